// File: rtl/beep_seq_if.sv
// CPU-side port bundle of the beep sequencer: tone-word write port, control inputs and status outputs.
interface beep_seq_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic                  WR;
  logic [15:0]           WDATA;
  logic                  CLR;
  logic                  IRQ_EN;
  logic [7:0]            CTL_OUT;
  logic                  BUSY;
  logic                  EMPTY;
  logic                  FULL;
  logic [DEPTH_LOG2:0]   LEVEL;
  logic                  OVF;
  logic                  IRQ;

  modport master (
    output WR, WDATA, CLR, IRQ_EN,
    input  CTL_OUT, BUSY, EMPTY, FULL, LEVEL, OVF, IRQ
  );

  modport slave (
    input  WR, WDATA, CLR, IRQ_EN,
    output CTL_OUT, BUSY, EMPTY, FULL, LEVEL, OVF, IRQ
  );
endinterface

// File: rtl/beep_sequencer.sv
// Plays queued {duration, tone} words back-to-back onto the beeper CTL byte, silence when the queue drains.
// Define BEEP_SEQ_IRQ_EN to enable the low-water interrupt; otherwise IRQ is held at 0.
module beep_sequencer #(
  parameter int DEPTH_LOG2 = 3,
  parameter int PRESC      = 50000,
  parameter int PRESC_W    = 16,
  parameter int LOW_MARK   = 2
) (
  input  logic      CLK,
  input  logic      nRST,
  beep_seq_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t                state_reg, state_next;
  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]         level_reg, level_next;
  logic                  empty_reg, full_reg, ovf_reg, irq_reg, irq_next;
  logic                  busy_reg, busy_next;
  logic [7:0]            ctl_reg, ctl_next;
  logic [8:0]            rem_reg, rem_next;
  logic [PRESC_W-1:0]    presc_reg, presc_next;
  logic                  pop, push, tick;
  logic [15:0]           head;

  // Head is read combinationally so a pop can load the tone on the same edge (gapless chaining).
  assign head = mem[rd_ptr_reg];
  assign tick = (presc_reg == PRESC_W'(PRESC - 1));

  always_comb begin
    state_next = state_reg;
    ctl_next   = ctl_reg;
    busy_next  = busy_reg;
    rem_next   = rem_reg;
    presc_next = presc_reg;
    pop        = 1'b0;
    if (bus.CLR) begin
      state_next = IDLE;
      ctl_next   = 8'h00;
      busy_next  = 1'b0;
      rem_next   = 9'd0;
      presc_next = '0;
    end else begin
      case (state_reg)
        IDLE: pop = !empty_reg;
        PLAY: begin
          if (tick) begin
            presc_next = '0;
            if (rem_reg == 9'd1) begin
              if (!empty_reg) begin
                pop = 1'b1;
              end else begin
                state_next = IDLE;
                ctl_next   = 8'h00;
                busy_next  = 1'b0;
                rem_next   = 9'd0;
              end
            end else begin
              rem_next = rem_reg - 9'd1;
            end
          end else begin
            presc_next = presc_reg + PRESC_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
      if (pop) begin
        state_next = PLAY;
        ctl_next   = head[7:0];
        busy_next  = 1'b1;
        // A zero duration byte means 256 ticks.
        rem_next   = {head[15:8] == 8'd0, head[15:8]};
        presc_next = '0;
      end
    end
  end

  assign push = bus.WR && !bus.CLR && (!full_reg || pop);

  always_comb begin
    level_next = level_reg;
    if (bus.CLR) begin
      level_next = '0;
    end else if (push && !pop) begin
      level_next = level_reg + LW'(1);
    end else if (pop && !push) begin
      level_next = level_reg - LW'(1);
    end
  end

`ifdef BEEP_SEQ_IRQ_EN
  assign irq_next = bus.IRQ_EN && busy_next && (level_next <= LW'(LOW_MARK));
`else
  logic unused_irq_en;
  assign unused_irq_en = bus.IRQ_EN;
  assign irq_next      = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.WDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg  <= IDLE;
      ctl_reg    <= 8'h00;
      busy_reg   <= 1'b0;
      rem_reg    <= 9'd0;
      presc_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      empty_reg  <= 1'b1;
      full_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      ctl_reg   <= ctl_next;
      busy_reg  <= busy_next;
      rem_reg   <= rem_next;
      presc_reg <= presc_next;
      level_reg <= level_next;
      empty_reg <= (level_next == '0);
      full_reg  <= (level_next == LW'(DEPTH));
      irq_reg   <= irq_next;
      if (bus.CLR) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        ovf_reg    <= 1'b0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
        if (bus.WR && full_reg && !pop) ovf_reg <= 1'b1;
      end
    end
  end

  assign bus.CTL_OUT = ctl_reg;
  assign bus.BUSY    = busy_reg;
  assign bus.EMPTY   = empty_reg;
  assign bus.FULL    = full_reg;
  assign bus.LEVEL   = level_reg;
  assign bus.OVF     = ovf_reg;
  assign bus.IRQ     = irq_reg;
endmodule

// File: tb/tb_beep_sequencer.sv
// Directed bench for beep_sequencer with PRESC=4 and an 8-entry queue; IRQ expectations follow BEEP_SEQ_IRQ_EN.
module tb_beep_sequencer;
  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   n;

`ifdef BEEP_SEQ_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  always #5 CLK = ~CLK;

  beep_seq_if #(.DEPTH_LOG2(3)) bus ();

  beep_sequencer #(
    .DEPTH_LOG2(3),
    .PRESC     (4),
    .PRESC_W   (16),
    .LOW_MARK  (2)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [15:0] d);
    bus.WR    = 1'b1;
    bus.WDATA = d;
    step();
    bus.WR    = 1'b0;
  endtask

  // Counts consecutive cycles (including the current one) that CTL_OUT equals v.
  task automatic hold(input logic [7:0] v, input int limit, output int cnt);
    cnt = 0;
    while (bus.CTL_OUT === v && cnt < limit) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.WR = 1'b0; bus.WDATA = 16'h0000; bus.CLR = 1'b0; bus.IRQ_EN = 1'b0;

    // 1: reset
    step(); step();
    nRST = 1'b1;
    chk("rst_ctl",   bus.CTL_OUT, 8'h00);
    chk("rst_empty", bus.EMPTY,   1'b1);
    chk("rst_level", bus.LEVEL,   4'd0);
    chk("rst_busy",  bus.BUSY,    1'b0);
    chk("rst_ovf",   bus.OVF,     1'b0);
    chk("rst_irq",   bus.IRQ,     1'b0);
    chk("rst_full",  bus.FULL,    1'b0);

    // 2: single tone, 3 ticks = 12 cycles, appears two cycles after the write
    wr(16'h0355);
    chk("t2_n1_ctl", bus.CTL_OUT, 8'h00);
    chk("t2_n1_lvl", bus.LEVEL,   4'd1);
    step();
    chk("t2_busy",   bus.BUSY,    1'b1);
    hold(8'h55, 100, n);
    chk("t2_len",    n,           12);
    chk("t2_end_ctl", bus.CTL_OUT, 8'h00);
    chk("t2_end_bsy", bus.BUSY,   1'b0);
    chk("t2_empty",  bus.EMPTY,   1'b1);

    // 3: gapless chain
    wr(16'h0210);
    wr(16'h0120);
    chk("t3_first",  bus.CTL_OUT, 8'h10);
    hold(8'h10, 100, n);
    chk("t3_len1",   n,           8);
    chk("t3_nogap",  bus.CTL_OUT, 8'h20);
    hold(8'h20, 100, n);
    chk("t3_len2",   n,           4);
    chk("t3_end",    bus.CTL_OUT, 8'h00);
    chk("t3_busy",   bus.BUSY,    1'b0);

    // 4: DUR=0 means 256 ticks
    wr(16'h0077);
    step();
    hold(8'h77, 2000, n);
    chk("t4_len",    n,           1024);
    chk("t4_end",    bus.CTL_OUT, 8'h00);

    // 5: overflow while a long tone plays, then CLR
    wr(16'h0099);
    step();
    chk("t5_play",   bus.CTL_OUT, 8'h99);
    for (int i = 0; i < 8; i++) wr(16'h01A0 + 16'(i));
    chk("t5_lvl8",   bus.LEVEL,   4'd8);
    chk("t5_full",   bus.FULL,    1'b1);
    chk("t5_noovf",  bus.OVF,     1'b0);
    wr(16'h01FF);
    chk("t5_ovf",    bus.OVF,     1'b1);
    chk("t5_lvl_keep", bus.LEVEL, 4'd8);
    bus.CLR = 1'b1;
    step();
    bus.CLR = 1'b0;
    chk("t5_clr_lvl", bus.LEVEL,  4'd0);
    chk("t5_clr_ovf", bus.OVF,    1'b0);
    chk("t5_clr_ctl", bus.CTL_OUT, 8'h00);
    chk("t5_clr_bsy", bus.BUSY,   1'b0);
    chk("t5_clr_emp", bus.EMPTY,  1'b1);
    // CLR and WR together: write discarded
    bus.CLR = 1'b1; bus.WR = 1'b1; bus.WDATA = 16'h0142;
    step();
    bus.CLR = 1'b0; bus.WR = 1'b0;
    chk("t5_cw_lvl", bus.LEVEL,   4'd0);
    chk("t5_cw_ovf", bus.OVF,     1'b0);
    step();
    chk("t5_cw_ctl", bus.CTL_OUT, 8'h00);
    chk("t5_cw_bsy", bus.BUSY,    1'b0);

    // reset mid-playback
    wr(16'h0366);
    step();
    chk("rm_play",   bus.CTL_OUT, 8'h66);
    step(); step(); step();
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    chk("rm_ctl",    bus.CTL_OUT, 8'h00);
    chk("rm_busy",   bus.BUSY,    1'b0);
    step(); step(); step();
    chk("rm_after",  bus.CTL_OUT, 8'h00);

    // 6: low-water IRQ
    bus.IRQ_EN = 1'b1;
    wr(16'h0231);
    wr(16'h0232);
    wr(16'h0233);
    wr(16'h0234);
    chk("t6_lvl3",   bus.LEVEL,   4'd3);
    chk("t6_irq_hi", bus.IRQ,     1'b0);
    n = 0;
    while (bus.LEVEL !== 4'd2 && n < 40) begin
      n++;
      step();
    end
    chk("t6_lvl2",   bus.LEVEL,   4'd2);
    chk("t6_irq_lo", bus.IRQ,     IRQ_ON);
    bus.IRQ_EN = 1'b0;
    step();
    chk("t6_irq_off", bus.IRQ,    1'b0);
    bus.IRQ_EN = 1'b1;
    step();
    chk("t6_irq_on", bus.IRQ,     IRQ_ON);
    bus.CLR = 1'b1;
    step();
    bus.CLR = 1'b0;
    chk("t6_irq_clr", bus.IRQ,    1'b0);
    chk("t6_busy",   bus.BUSY,    1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
